// File: rtl/jedro_1_ifu_prefetch.sv
// jedro_1_ifu_prefetch
//
// Instruction fetch unit with a prefetch FIFO. It issues in-order word fetches
// on a req/gnt/rvalid memory port, buffers up to FIFO_DEPTH {addr, data} pairs,
// and presents the oldest one to decode. A jump flushes the buffer, redirects
// both the fetch PC and the response PC, and marks every request still in
// flight as stale, so its response is dropped when it arrives.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   jmp_instr_i     one-cycle redirect pulse; wins over every other event
//   jmp_addr_i      redirect target; bits [1:0] are ignored
//   instr_o         instruction at the FIFO head (0 when the FIFO is empty)
//   instr_addr_o    address of instr_o (0 when the FIFO is empty)
//   instr_valid_o   FIFO head valid
//   instr_ready_i   decode accepts the head
//   mem_req_o       fetch request, driven from registered state only
//   mem_addr_o      fetch address (the fetch PC)
//   mem_gnt_i       request accepted this cycle
//   mem_rvalid_i    response valid; never back-pressured
//   mem_rdata_i     response data
//
// Handshakes: the decode side transfers on instr_valid_o & instr_ready_i; once
// raised, instr_valid_o and the head contents hold until the transfer or a
// jump. The memory side transfers a request on mem_req_o & mem_gnt_i, and
// mem_addr_o holds until that grant unless a jump abandons the request.

module jedro_1_ifu_prefetch #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  jmp_instr_i,
    input  logic [ADDR_WIDTH-1:0] jmp_addr_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] instr_addr_o,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned SW = CW + 1;
    localparam logic [SW-1:0]         DEPTH_S = SW'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] WORD    = ADDR_WIDTH'(4);

    logic                  run;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] resp_pc;
    logic [CW-1:0]         count;
    logic [CW-1:0]         outst;
    logic [CW-1:0]         disc;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [ADDR_WIDTH-1:0] addr_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];

    logic [ADDR_WIDTH-1:0] jmp_tgt;
    logic                  grant;
    logic                  push;
    logic                  pop;
    logic [CW-1:0]         in_flight_next;

    assign jmp_tgt = jmp_addr_i & ~ADDR_WIDTH'(3);

    // Credit rule: a request is only issued if its response is guaranteed a
    // free FIFO slot. run keeps the port quiet during reset and the first
    // cycle after it.
    assign mem_req_o  = run & (({1'b0, count} + {1'b0, outst}) < DEPTH_S);
    assign mem_addr_o = fetch_pc;
    assign grant      = mem_req_o & mem_gnt_i;

    // Responses arriving while disc is non-zero belong to requests issued
    // before the latest jump; a response in the jump cycle itself is stale too.
    assign push = mem_rvalid_i & (disc == '0) & ~jmp_instr_i;
    assign pop  = instr_valid_o & instr_ready_i & ~jmp_instr_i;

    assign in_flight_next = outst + CW'(grant) - CW'(mem_rvalid_i);

    assign instr_valid_o = (count != '0);
    assign instr_o       = instr_valid_o ? data_mem[rd_ptr] : '0;
    assign instr_addr_o  = instr_valid_o ? addr_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= resp_pc;
            data_mem[wr_ptr] <= mem_rdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run      <= 1'b0;
            fetch_pc <= BOOT_ADDR;
            resp_pc  <= BOOT_ADDR;
            count    <= '0;
            outst    <= '0;
            disc     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            run   <= 1'b1;
            outst <= in_flight_next;
            if (jmp_instr_i) begin
                fetch_pc <= jmp_tgt;
                resp_pc  <= jmp_tgt;
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                // Everything still outstanding after this cycle is stale.
                disc     <= in_flight_next;
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + WORD;
                end
                if (push) begin
                    wr_ptr  <= wr_ptr + PW'(1);
                    resp_pc <= resp_pc + WORD;
                end
                if (mem_rvalid_i && (disc != '0)) begin
                    disc <= disc - CW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

endmodule

// File: tb/tb_jedro_1_ifu_prefetch.sv
// Bench for jedro_1_ifu_prefetch: a memory model with configurable grant rate
// and response latency, directed timing scenarios, then a randomized run. The
// reference model says the delivered stream is the sequence of consecutive
// words starting at the last jump target (or boot address), data = addr >> 2.

module tb_jedro_1_ifu_prefetch;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          jmp_instr_i = 1'b0;
    logic [AW-1:0] jmp_addr_i = '0;
    logic [DW-1:0] instr_o;
    logic [AW-1:0] instr_addr_o;
    logic          instr_valid_o;
    logic          instr_ready_i = 1'b0;
    logic          mem_req_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_gnt_i = 1'b0;
    logic          mem_rvalid_i = 1'b0;
    logic [DW-1:0] mem_rdata_i = '0;

    jedro_1_ifu_prefetch #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (DEPTH),
        .BOOT_ADDR  ('0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .jmp_instr_i   (jmp_instr_i),
        .jmp_addr_i    (jmp_addr_i),
        .instr_o       (instr_o),
        .instr_addr_o  (instr_addr_o),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bench state ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_gnt = 0;
    int n_pop = 0;
    int gnt_pct = 100;
    int lat_lo = 1;
    int lat_hi = 1;

    logic [AW-1:0] pend_addr[$];
    int            pend_due[$];

    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] model_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    // ---------------- scoreboard ----------------
    // exp_q holds the next expected addresses of the delivered stream.
    task automatic sb_refill();
        while (exp_q.size() < 4) begin
            exp_q.push_back(model_pc);
            model_pc = model_pc + 32'd4;
        end
    endtask

    task automatic sb_restart(input logic [AW-1:0] a);
        exp_q.delete();
        model_pc = a & ~32'd3;
        sb_refill();
    endtask

    // ---------------- drivers ----------------
    // One clock cycle, entered and left at the falling edge.
    task automatic step(input logic rdy, input logic jmp, input logic [AW-1:0] jaddr);
        logic g;
        logic rv;
        int   lat;
        g  = mem_req_o && ($urandom_range(99) < gnt_pct);
        rv = (pend_addr.size() > 0) && (pend_due[0] <= cyc);
        mem_gnt_i     = g;
        mem_rvalid_i  = rv;
        mem_rdata_i   = rv ? word_of(pend_addr[0]) : $urandom();
        instr_ready_i = rdy;
        jmp_instr_i   = jmp;
        jmp_addr_i    = jaddr;

        if (instr_valid_o && rdy && !jmp) begin
            check("pop_addr", instr_addr_o, exp_q[0]);
            check("pop_data", instr_o, word_of(exp_q[0]));
            void'(exp_q.pop_front());
            sb_refill();
            n_pop++;
        end
        if (rv) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (g) begin
            lat = $urandom_range(lat_hi, lat_lo);
            pend_addr.push_back(mem_addr_o);
            pend_due.push_back(cyc + lat);
            n_gnt++;
        end
        if (jmp) sb_restart(jaddr);

        @(posedge clk);
        cyc++;
        @(negedge clk);
        jmp_instr_i  = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
    endtask

    // Holds rst for ncyc rising edges; returns at the falling edge where rst
    // drops. The memory forgets everything granted before reset.
    task automatic do_reset(input int ncyc);
        rst           = 1'b1;
        mem_gnt_i     = 1'b0;
        mem_rvalid_i  = 1'b0;
        instr_ready_i = 1'b0;
        jmp_instr_i   = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        repeat (ncyc) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        rst = 1'b0;
        sb_restart('0);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (!instr_valid_o && n < budget) begin
            step(1'b0, 1'b0, '0);
            n++;
        end
        check(tag, 32'(instr_valid_o), 32'd1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        // Free run after reset, zero-wait memory.
        do_reset(3);
        check("rst_req", 32'(mem_req_o), 32'd0);
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_instr_addr", instr_addr_o, 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
        step(1'b1, 1'b0, '0);
        check("first_req", 32'(mem_req_o), 32'd1);
        check("first_req_addr", mem_addr_o, 32'd0);
        step(1'b1, 1'b0, '0);
        check("first_valid_early", 32'(instr_valid_o), 32'd0);
        step(1'b1, 1'b0, '0);
        check("first_valid", 32'(instr_valid_o), 32'd1);
        for (int k = 0; k < 8; k++) begin
            check("run_valid", 32'(instr_valid_o), 32'd1);
            check("run_data", instr_o, 32'(k));
            check("run_addr", instr_addr_o, 32'(4 * k));
            step(1'b1, 1'b0, '0);
        end

        // Steady-state jump to 0x4.
        step(1'b1, 1'b1, 32'h4);
        check("jmp_j1_valid", 32'(instr_valid_o), 32'd0);
        check("jmp_j1_req", 32'(mem_req_o), 32'd1);
        check("jmp_j1_addr", mem_addr_o, 32'h4);
        step(1'b1, 1'b0, '0);
        check("jmp_j2_valid", 32'(instr_valid_o), 32'd0);
        step(1'b1, 1'b0, '0);
        check("jmp_j3_valid", 32'(instr_valid_o), 32'd1);
        check("jmp_j3_addr", instr_addr_o, 32'h4);
        check("jmp_j3_data", instr_o, 32'd1);
        repeat (6) step(1'b1, 1'b0, '0);

        // Back-to-back jumps, the second one wins.
        step(1'b1, 1'b1, 32'h10);
        step(1'b1, 1'b1, 32'h20);
        wait_valid("b2b_timeout", 20);
        check("b2b_addr", instr_addr_o, 32'h20);
        check("b2b_data", instr_o, 32'd8);
        repeat (8) step(1'b1, 1'b0, '0);

        // Back-pressure: exactly DEPTH grants, then the port goes quiet.
        do_reset(2);
        n_gnt = 0;
        repeat (10) step(1'b0, 1'b0, '0);
        check("bp_grants", 32'(n_gnt), 32'(DEPTH));
        check("bp_req_off", 32'(mem_req_o), 32'd0);
        check("bp_full_valid", 32'(instr_valid_o), 32'd1);
        for (int k = 0; k < 16; k++) begin
            check("bp_release_valid", 32'(instr_valid_o), 32'd1);
            step(1'b1, 1'b0, '0);
        end

        // Jump with three stale requests, 2-cycle response latency.
        do_reset(2);
        lat_lo = 2;
        lat_hi = 2;
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 32'h40);
        wait_valid("stale_timeout", 20);
        check("stale_addr", instr_addr_o, 32'h40);
        check("stale_data", instr_o, 32'h10);
        repeat (12) step(1'b1, 1'b0, '0);

        // Reset while the FIFO is filling and requests are in flight.
        repeat (3) step(1'b0, 1'b0, '0);
        do_reset(1);
        check("midrst_valid", 32'(instr_valid_o), 32'd0);
        check("midrst_mem_addr", mem_addr_o, 32'd0);
        check("midrst_instr", instr_o, 32'd0);
        wait_valid("midrst_timeout", 20);
        check("midrst_restart_addr", instr_addr_o, 32'd0);
        check("midrst_restart_data", instr_o, 32'd0);
        repeat (6) step(1'b1, 1'b0, '0);

        // Randomized run: random grants, latencies, readiness, jumps, resets.
        gnt_pct = 70;
        lat_lo  = 1;
        lat_hi  = 4;
        n_pop   = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(999) < 3) begin
                do_reset(1);
            end else begin
                step($urandom_range(99) < 70, $urandom_range(99) < 3, $urandom());
            end
        end
        check("rand_progress", 32'(n_pop > 300), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
